ddr3_cmd_arbiter: RTL
=====================

DDR3_CMD_ARBITER -- requirements
Module: ddr3_cmd_arbiter

Interface
REQ-001 SHALL have parameter DDR_ROW_BITS, default 13, meaning DDR3 row/address width (RSB = DDR_ROW_BITS-1).
REQ-002 SHALL have parameter STARVE_MAX, default 8, meaning the number of consecutive A-transfers after which a waiting B is forced.
REQ-003 SHALL have port clock, input, 1, the only clock.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-005 SHALL have ports a_req_i/a_seq_i (input, 1 each), a_cmd_i (input, 3), a_ba_i (input, 3), a_adr_i (input, RSB+1), and a_rdy_o (output, 1). These form the high-priority fast-path command requester A.
REQ-006 SHALL have ports b_req_i/b_seq_i/b_cmd_i/b_ba_i/b_adr_i/b_rdy_o with the same widths, forming the low-priority controller requester B.
REQ-007 SHALL have ports ddl_req_o, ddl_seq_o (output, 1 each); ddl_cmd_o, ddl_ba_o (output, 3 each); ddl_adr_o (output, RSB+1); and ddl_rdy_i, ddl_ref_i (input, 1 each). These connect to the DDL command port.
REQ-008 SHALL have port grant_o, output, 2, giving the current owner: 2'b01 = A, 2'b10 = B, 2'b00 = none.

Function
REQ-009 SHALL implement FSM states IDLE, GNT_A and GNT_B, held in registers.
REQ-010 In IDLE with ddl_ref_i low: a_req_i -> GNT_A; else b_req_i -> GNT_B. Exception: if starve_cnt == STARVE_MAX and b_req_i is high, go to GNT_B.
REQ-011 In IDLE with ddl_ref_i high, SHALL remain in IDLE regardless of requests. A refresh never interrupts an already-granted owner.
REQ-012 Grant latency SHALL be exactly one cycle: a request seen in IDLE at edge N gives ddl_req_o high after edge N+1.
REQ-013 While in GNT_x, the outputs SHALL be combinational copies of owner x: ddl_req_o = x_req_i, ddl_seq_o = x_seq_i, ddl_cmd_o/ba/adr = x fields.
REQ-014 x_rdy_o = ddl_rdy_i while in GNT_x; the non-owner's rdy SHALL be 0. In IDLE, both rdy outputs SHALL be 0.
REQ-015 A transfer SHALL occur when ddl_req_o && ddl_rdy_i.
REQ-016 On a transfer with x_seq_i = 0, return to IDLE. With x_seq_i = 1, remain in GNT_x (sequence lock: ACT->RD with no interleaving).
REQ-017 In GNT_x with x_req_i = 0 and no transfer, return to IDLE next cycle.
REQ-018 When not in GNT_x: ddl_req_o = 0, ddl_seq_o = 0, ddl_cmd_o = CMD_NOOP (3'b111), ddl_ba_o = 0, ddl_adr_o = 0.
REQ-019 starve_cnt (width clog2(STARVE_MAX+1)) SHALL behave as follows:
 - increment on each A-transfer while b_req_i = 1;
 - saturate at STARVE_MAX;
 - clear on any B-transfer or when b_req_i = 0 in IDLE.
REQ-020 When A and B both assert in the same cycle in IDLE, A SHALL win unless REQ-010's starvation rule applies.
REQ-021 Requester inputs SHALL NOT be registered. Outputs carry no added latency beyond REQ-012.

Reset
REQ-022 Asserting reset SHALL asynchronously force:
 - state IDLE, starve_cnt 0, grant_o 2'b00;
 - all outputs to REQ-018 values;
 - a_rdy_o = b_rdy_o = 0.
REQ-023 Reset asserted mid-sequence SHALL abandon the sequence. No output glitches to the previous owner after reset is released.

Configuration
REQ-024 With DDR3_ARB_STATS_EN defined, SHALL add outputs a_count_o and b_count_o (16 bits each). Each counts its requester's transfers, wraps at 16'hFFFF->0, and resets to 0.
REQ-025 Without DDR3_ARB_STATS_EN, those ports and counters SHALL NOT exist. All other behaviour is identical.

Verification
REQ-026 Single A: a_req=1, a_cmd=3'b101, a_seq=0, ddl_rdy=1 -> cycle+1: grant_o=01, ddl_cmd_o=101, a_rdy_o=1; next cycle: IDLE, ddl_cmd_o=111.
REQ-027 Sequence lock: A issues ACT (3'b011, seq=1) then RD (3'b101, seq=0) while b_req=1 -> b_rdy_o stays 0 until both A transfers complete; then grant_o=10.
REQ-028 Starvation: a_req and b_req held high with STARVE_MAX=8 -> B granted after exactly 8 A transfers; starve_cnt then returns to 0.
REQ-029 Refresh: ddl_ref_i=1 in IDLE with a_req=1 for 5 cycles -> grant_o stays 00 and ddl_req_o stays 0; ref drops -> grant_o=01 one cycle later.
REQ-030 Reset mid-sequence: in GNT_B with b_seq=1, pulse reset -> immediately grant_o=00, ddl_cmd_o=111, b_rdy_o=0. With DDR3_ARB_STATS_EN defined, b_count_o=0.

Source files
------------

// File: rtl/ddr3_cmd_arbiter.sv
// rtl/ddr3_cmd_arbiter.sv - two-requester DDR3 command arbiter with sequence lock and B anti-starvation
// Optional transfer statistics are enabled by defining DDR3_ARB_STATS_EN.
module ddr3_cmd_arbiter #(
    parameter int DDR_ROW_BITS = 13,
    parameter int STARVE_MAX   = 8
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    a_req_i,
    input  logic                    a_seq_i,
    input  logic [2:0]              a_cmd_i,
    input  logic [2:0]              a_ba_i,
    input  logic [DDR_ROW_BITS-1:0] a_adr_i,
    output logic                    a_rdy_o,

    input  logic                    b_req_i,
    input  logic                    b_seq_i,
    input  logic [2:0]              b_cmd_i,
    input  logic [2:0]              b_ba_i,
    input  logic [DDR_ROW_BITS-1:0] b_adr_i,
    output logic                    b_rdy_o,

    output logic                    ddl_req_o,
    output logic                    ddl_seq_o,
    output logic [2:0]              ddl_cmd_o,
    output logic [2:0]              ddl_ba_o,
    output logic [DDR_ROW_BITS-1:0] ddl_adr_o,
    input  logic                    ddl_rdy_i,
    input  logic                    ddl_ref_i,

`ifdef DDR3_ARB_STATS_EN
    output logic [15:0]             a_count_o,
    output logic [15:0]             b_count_o,
`endif
    output logic [1:0]              grant_o
);

    localparam logic [2:0] CMD_NOOP = 3'b111;
    localparam int         CW       = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_A = 2'b01,
        GNT_B = 2'b10
    } state_t;

    state_t          state;
    logic [CW-1:0]   starve_cnt;
    logic            a_xfer;
    logic            b_xfer;
    logic            b_forced;

    assign a_xfer   = (state == GNT_A) && a_req_i && ddl_rdy_i;
    assign b_xfer   = (state == GNT_B) && b_req_i && ddl_rdy_i;
    assign b_forced = (starve_cnt == STARVE_LIM) && b_req_i;

    // grant_o is updated alongside state so it never lags or leads the owner.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant_o    <= 2'b00;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!b_req_i)
                        starve_cnt <= '0;
                    if (!ddl_ref_i) begin
                        if (b_forced) begin
                            state   <= GNT_B;
                            grant_o <= 2'b10;
                        end else if (a_req_i) begin
                            state   <= GNT_A;
                            grant_o <= 2'b01;
                        end else if (b_req_i) begin
                            state   <= GNT_B;
                            grant_o <= 2'b10;
                        end
                    end
                end
                GNT_A: begin
                    if (a_xfer) begin
                        if (b_req_i && (starve_cnt != STARVE_LIM))
                            starve_cnt <= starve_cnt + 1'b1;
                        if (!a_seq_i) begin
                            state   <= IDLE;
                            grant_o <= 2'b00;
                        end
                    end else if (!a_req_i) begin
                        state   <= IDLE;
                        grant_o <= 2'b00;
                    end
                end
                GNT_B: begin
                    if (b_xfer) begin
                        starve_cnt <= '0;
                        if (!b_seq_i) begin
                            state   <= IDLE;
                            grant_o <= 2'b00;
                        end
                    end else if (!b_req_i) begin
                        state   <= IDLE;
                        grant_o <= 2'b00;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_o <= 2'b00;
                end
            endcase
        end
    end

    // Owner fields pass straight through so the grant adds no latency of its own.
    always_comb begin
        ddl_req_o = 1'b0;
        ddl_seq_o = 1'b0;
        ddl_cmd_o = CMD_NOOP;
        ddl_ba_o  = 3'b000;
        ddl_adr_o = '0;
        a_rdy_o   = 1'b0;
        b_rdy_o   = 1'b0;
        case (state)
            GNT_A: begin
                ddl_req_o = a_req_i;
                ddl_seq_o = a_seq_i;
                ddl_cmd_o = a_cmd_i;
                ddl_ba_o  = a_ba_i;
                ddl_adr_o = a_adr_i;
                a_rdy_o   = ddl_rdy_i;
            end
            GNT_B: begin
                ddl_req_o = b_req_i;
                ddl_seq_o = b_seq_i;
                ddl_cmd_o = b_cmd_i;
                ddl_ba_o  = b_ba_i;
                ddl_adr_o = b_adr_i;
                b_rdy_o   = ddl_rdy_i;
            end
            default: ;
        endcase
    end

`ifdef DDR3_ARB_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_count_o <= 16'h0000;
            b_count_o <= 16'h0000;
        end else begin
            if (a_xfer)
                a_count_o <= a_count_o + 16'h0001;
            if (b_xfer)
                b_count_o <= b_count_o + 16'h0001;
        end
    end
`endif

endmodule
